// File: rtl/uop_sequencer_if.sv
// Handshake bundle between decode, the micro-op sequencer and the execute stage.
// The sequencer takes the slave view; decode/execute (or a bench) take the master view.
interface uop_sequencer_if #(
    parameter int UOP_W = 20
);
    logic             feed_req;
    logic             feed_ack;
    logic [UOP_W-1:0] uop_0_in;
    logic [UOP_W-1:0] uop_1_in;
    logic [UOP_W-1:0] uop_2_in;
    logic [1:0]       uop_count;
    logic [UOP_W-1:0] uop_out;
    logic             uop_valid;
    logic             uop_last;
    logic             exec_ready;

    modport slave (
        input  feed_ack, uop_0_in, uop_1_in, uop_2_in, uop_count, exec_ready,
        output feed_req, uop_out, uop_valid, uop_last
    );

    modport master (
        output feed_ack, uop_0_in, uop_1_in, uop_2_in, uop_count, exec_ready,
        input  feed_req, uop_out, uop_valid, uop_last
    );
endinterface

// File: rtl/uop_sequencer.sv
// Issue controller: buffers one decoded instruction and issues its micro-ops
// (uop_2, uop_1, uop_0) one per cycle to execute, counting retired instructions.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no instruction buffered; requesting a new one from decode
//  S_ISSUE | instruction buffered; rem = micro-ops left to issue minus one
module uop_sequencer #(
    parameter int UOP_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    uop_sequencer_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]       state;
    logic [1:0]       rem;
    logic [UOP_W-1:0] buf0;
    logic [UOP_W-1:0] buf1;
    logic [UOP_W-1:0] buf2;
    logic             in_issue;
    logic             last_pending;
    logic             issue;
    logic             capture;
    logic [1:0]       rem_load;
    logic [UOP_W-1:0] uop_sel;

    assign in_issue     = (state == S_ISSUE);
    assign last_pending = in_issue && (rem == 2'd0);

    // The final issue overlaps the next capture so back-to-back instructions have no bubble.
    assign bus.feed_req  = ~hold & ~flush & (~in_issue | (last_pending & bus.exec_ready));
    assign bus.uop_valid = in_issue & ~hold;
    assign bus.uop_last  = bus.uop_valid & (rem == 2'd0);
    assign bus.uop_out   = uop_sel;
    assign busy          = in_issue;

    assign issue    = bus.uop_valid & bus.exec_ready;
    assign capture  = bus.feed_req & bus.feed_ack;
    assign rem_load = (bus.uop_count == 2'd3) ? 2'd2 : bus.uop_count;

    always_comb begin
        uop_sel = buf0;
        case (rem)
            2'd2:    uop_sel = buf2;
            2'd1:    uop_sel = buf1;
            default: uop_sel = buf0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rem     <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
            buf2    <= '0;
            retired <= '0;
        end else if (flush) begin
            // Flush overrides hold: the buffered instruction is dropped without retiring.
            state <= S_IDLE;
            rem   <= 2'd0;
        end else if (!hold) begin
            if (issue) begin
                if (rem != 2'd0) begin
                    rem <= rem - 2'd1;
                end else begin
                    retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                    state   <= S_IDLE;
                end
            end
            // Capture is placed last so it overrides the return to idle on a final issue.
            if (capture) begin
                buf0  <= bus.uop_0_in;
                buf1  <= bus.uop_1_in;
                buf2  <= bus.uop_2_in;
                rem   <= rem_load;
                state <= S_ISSUE;
            end
        end
    end
endmodule

// File: tb/tb_uop_sequencer.sv
// Directed, table-driven bench for uop_sequencer with hand-computed expectations.
module tb_uop_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        busy;
    logic [15:0] retired;

    uop_sequencer_if #(.UOP_W(20)) bus ();

    uop_sequencer #(.UOP_W(20), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .flush   (flush),
        .bus     (bus),
        .busy    (busy),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, h, f, a;
        logic [1:0]  c;
        logic [19:0] x2, x1, x0;
        logic        rd;
        logic        e_freq, e_val, e_last;
        logic [19:0] e_out;
        logic        e_busy;
        logic [15:0] e_ret;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic f, input logic a,
                         input logic [1:0] c, input logic [19:0] x2, input logic [19:0] x1,
                         input logic [19:0] x0, input logic rd);
        rst = r; hold = h; flush = f;
        bus.feed_ack = a; bus.uop_count = c;
        bus.uop_2_in = x2; bus.uop_1_in = x1; bus.uop_0_in = x0;
        bus.exec_ready = rd;
    endtask

    task automatic check_all(input int row, input logic ef, input logic ev, input logic el,
                             input logic chk_out, input logic [19:0] eo, input logic eb,
                             input logic [15:0] er);
        chk("feed_req", row, bus.feed_req, ef);
        chk("uop_valid", row, bus.uop_valid, ev);
        chk("uop_last", row, bus.uop_last, el);
        if (chk_out) chk("uop_out", row, bus.uop_out, eo);
        chk("busy", row, busy, eb);
        chk("retired", row, retired, er);
    endtask

    task automatic add(input logic r, input logic h, input logic f, input logic a,
                       input logic [1:0] c, input logic [19:0] x2, input logic [19:0] x1,
                       input logic [19:0] x0, input logic rd,
                       input logic ef, input logic ev, input logic el, input logic [19:0] eo,
                       input logic eb, input logic [15:0] er);
        vec_t v;
        v.r = r; v.h = h; v.f = f; v.a = a; v.c = c;
        v.x2 = x2; v.x1 = x1; v.x0 = x0; v.rd = rd;
        v.e_freq = ef; v.e_val = ev; v.e_last = el; v.e_out = eo;
        v.e_busy = eb; v.e_ret = er;
        tbl.push_back(v);
    endtask

    initial begin
        drive(1, 0, 0, 0, 2'd0, 20'h0, 20'h0, 20'h0, 0);

        //   r h f a cnt  uop_2     uop_1     uop_0     rdy  freq val last out      busy ret
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   1,0,0, 20'h0,    0, 16'd0); // 0 idle after reset
        add(0,0,0,1,2'd2, 20'h0CCCC,20'h0BBBB,20'h0AAAA,1,   1,0,0, 20'h0,    0, 16'd0); // 1 capture 3-uop
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h0CCCC,1, 16'd0);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h0BBBB,1, 16'd0);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,1,1, 20'h0AAAA,1, 16'd0);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd1); // 5
        add(0,0,0,1,2'd0, 20'h0,    20'h0,    20'h00011,1,   1,0,0, 20'h0,    0, 16'd1); // 6 back-to-back
        add(0,0,0,1,2'd0, 20'h0,    20'h0,    20'h00022,1,   1,1,1, 20'h00011,1, 16'd1);
        add(0,0,0,1,2'd0, 20'h0,    20'h0,    20'h00033,1,   1,1,1, 20'h00022,1, 16'd2);
        add(0,0,0,1,2'd0, 20'h0,    20'h0,    20'h00044,1,   1,1,1, 20'h00033,1, 16'd3);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,1,1, 20'h00044,1, 16'd4); // 10
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd5);
        add(0,0,0,1,2'd1, 20'h0,    20'h12345,20'h6789A,0,   1,0,0, 20'h0,    0, 16'd5); // 12 stall
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   0,1,0, 20'h12345,1, 16'd5);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   0,1,0, 20'h12345,1, 16'd5);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   0,1,0, 20'h12345,1, 16'd5); // 15
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h12345,1, 16'd5);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,1,1, 20'h6789A,1, 16'd5);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd6);
        add(0,0,0,1,2'd2, 20'h11111,20'h22222,20'h33333,1,   1,0,0, 20'h0,    0, 16'd6); // 19 flush
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h11111,1, 16'd6); // 20
        add(0,0,1,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h22222,1, 16'd6);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd6);
        add(0,0,0,1,2'd3, 20'h0F00F,20'h0E00E,20'h0D00D,1,   1,0,0, 20'h0,    0, 16'd6); // 23 hold, cnt=3
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h0F00F,1, 16'd6);
        add(0,1,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,0,0, 20'h0,    1, 16'd6); // 25
        add(0,1,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,0,0, 20'h0,    1, 16'd6);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   0,1,0, 20'h0E00E,1, 16'd6);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,1,1, 20'h0D00D,1, 16'd6);
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd7);
        add(0,1,0,1,2'd0, 20'h0,    20'h0,    20'h55555,1,   0,0,0, 20'h0,    0, 16'd7); // 30 hold blocks capture
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd7);
        add(0,0,1,1,2'd0, 20'h0,    20'h0,    20'h66666,1,   0,0,0, 20'h0,    0, 16'd7); // flush blocks capture
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    1,   1,0,0, 20'h0,    0, 16'd7);
        add(0,0,0,1,2'd1, 20'h0,    20'h0ABCD,20'h01234,0,   1,0,0, 20'h0,    0, 16'd7); // flush beats hold
        add(0,1,1,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   0,0,0, 20'h0,    1, 16'd7); // 35
        add(0,0,0,0,2'd0, 20'h0,    20'h0,    20'h0,    0,   1,0,0, 20'h0,    0, 16'd7);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all(-1, 1, 0, 0, 1, 20'h0, 0, 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].a, tbl[i].c,
                  tbl[i].x2, tbl[i].x1, tbl[i].x0, tbl[i].rd);
            #1;
            check_all(i, tbl[i].e_freq, tbl[i].e_val, tbl[i].e_last, tbl[i].e_val,
                      tbl[i].e_out, tbl[i].e_busy, tbl[i].e_ret);
        end

        // Reset mid-issue, asserted together with flush and hold, discards everything.
        @(negedge clk);
        drive(0, 0, 0, 1, 2'd2, 20'h71111, 20'h72222, 20'h73333, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 2'd0, 20'h0, 20'h0, 20'h0, 1);
        #1;
        chk("pre_rst_out", 100, bus.uop_out, 20'h71111);
        @(negedge clk);
        drive(1, 1, 1, 0, 2'd0, 20'h0, 20'h0, 20'h0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 2'd0, 20'h0, 20'h0, 20'h0, 1);
        #1;
        check_all(101, 1, 0, 0, 1, 20'h0, 0, 16'd0);

        // First instruction after that reset retires from zero.
        @(negedge clk);
        drive(0, 0, 0, 1, 2'd0, 20'h0, 20'h0, 20'h00077, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 2'd0, 20'h0, 20'h0, 20'h0, 1);
        #1;
        check_all(102, 1, 1, 1, 1, 20'h00077, 1, 16'd0);
        @(negedge clk);
        #1;
        check_all(103, 1, 0, 0, 0, 20'h0, 0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
